// File: rtl/key_exp_iter.sv
// Iterative AES-128/192/256 key expander: one schedule word per clock through a
// single shared SubWord unit, round keys read back by index from a word store.
module key_exp_iter #(
  parameter int MAX_NK     = 8,
  parameter bit RK_REG_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [0:255] key_in,
  output logic         busy,
  output logic         done,
  output logic         ready,
  output logic         err,
  output logic [3:0]   nr,
  input  logic [3:0]   rk_idx,
  output logic [0:127] rk_out
);

  localparam int DEPTH = 4 * (MAX_NK + 7);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXP, S_FIN} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as b^254 (square-and-multiply), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = b;
    for (int n = 1; n < 8; n++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t         state_q, state_d;
  logic [5:0]     i_q, i_d;
  logic [2:0]     k_q, k_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [3:0]     nk_q, nk_d;
  logic [3:0]     nr_q, nr_d;
  logic [0:255]   key_q, key_d;
  logic           ready_q, ready_d;
  logic           err_q, err_d;
  logic [31:0]    w_q [DEPTH];

  logic [3:0]     mode_nk, mode_nr;
  logic           mode_ok;
  logic           k_last;
  logic [5:0]     last_idx;
  logic [31:0]    prev_w, old_w, sub_in, sub_out, temp, new_w;

  assign mode_nk  = 4'd4 + {1'b0, mode, 1'b0};
  assign mode_nr  = 4'd10 + {1'b0, mode, 1'b0};
  assign mode_ok  = (mode != 2'd3) && (int'(mode_nk) <= MAX_NK);
  assign k_last   = (k_q == 3'(nk_q - 4'd1));
  assign last_idx = {nr_q, 2'b11};

  // Schedule step for word i; k tracks i mod Nk so no divider is needed.
  always_comb begin
    prev_w  = w_q[i_q - 6'd1];
    old_w   = w_q[i_q - {2'b00, nk_q}];
    sub_in  = (k_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out = sub_word(sub_in);
    temp    = prev_w;
    if (k_q == 3'd0) begin
      temp = sub_out ^ {rcon_q, 24'h000000};
    end else if (nk_q == 4'd8 && k_q == 3'd4) begin
      temp = sub_out;
    end
    new_w = old_w ^ temp;
  end

  // NOTE: every variable gets its default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    rcon_d  = rcon_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    key_d   = key_q;
    ready_d = ready_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode_ok) begin
            nk_d    = mode_nk;
            nr_d    = mode_nr;
            key_d   = key_in;
            ready_d = 1'b0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        i_d     = {2'b00, nk_q};
        k_d     = 3'd0;
        rcon_d  = 8'h01;
        state_d = S_EXP;
      end
      S_EXP: begin
        i_d = i_q + 6'd1;
        k_d = k_last ? 3'd0 : k_q + 3'd1;
        if (k_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == last_idx) begin
          ready_d = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      k_q     <= '0;
      rcon_q  <= 8'h01;
      nk_q    <= '0;
      nr_q    <= '0;
      key_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      k_q     <= k_d;
      rcon_q  <= rcon_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      key_q   <= key_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the word store is reset on purpose so a restart never exposes an earlier key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < DEPTH; n++) w_q[n] <= '0;
    end else if (state_q == S_LOAD) begin
      for (int j = 0; j < 8; j++) begin
        if (j < int'(nk_q)) w_q[j] <= key_q[32*j +: 32];
      end
    end else if (state_q == S_EXP) begin
      w_q[i_q] <= new_w;
    end
  end

  logic [5:0]   rd_base;
  logic [0:127] rk_comb;

  assign rd_base = {rk_idx, 2'b00};
  assign rk_comb = (rk_idx <= nr_q) ?
                   {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]} :
                   '0;

  if (RK_REG_OUT) begin : g_rk_reg
    logic [0:127] rk_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rk_q <= '0;
      else     rk_q <= rk_comb;
    end
    assign rk_out = rk_q;
  end else begin : g_rk_comb
    assign rk_out = rk_comb;
  end

  assign busy  = (state_q == S_LOAD) || (state_q == S_EXP);
  assign done  = (state_q == S_FIN);
  assign ready = ready_q;
  assign err   = err_q;
  assign nr    = nr_q;

endmodule

// File: tb/tb_key_exp_iter.sv
// Scoreboard bench for key_exp_iter: FIPS-197 key vectors, error/ignored starts,
// async reset mid-run and back-to-back runs.
module tb_key_exp_iter;

  localparam logic [0:255] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [0:255] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [0:255] key_in = '0;
  logic [3:0]   rk_idx = 4'd0;
  logic         busy, done, ready, err;
  logic [3:0]   nr;
  logic [0:127] rk_out;

  key_exp_iter #(.MAX_NK(8), .RK_REG_OUT(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key_in(key_in),
    .busy(busy), .done(done), .ready(ready), .err(err), .nr(nr),
    .rk_idx(rk_idx), .rk_out(rk_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct { string name; logic [127:0] val; } rd_exp_t;
  typedef struct { int cyc; logic [3:0] nr; }       done_exp_t;
  typedef struct { int cyc; logic rdy; }            err_exp_t;

  rd_exp_t   rd_exp_q[$];
  done_exp_t done_exp_q[$];
  err_exp_t  err_exp_q[$];

  logic rd_strobe = 1'b0;
  logic rd_pend   = 1'b0;
  int   done_seen = 0;
  rd_exp_t   re;
  done_exp_t de;
  err_exp_t  ee;

  always @(posedge clk) rd_pend <= rd_strobe;

  // Monitor: compares whenever the DUT presents done, err or a requested read.
  always @(negedge clk) begin
    if (done) begin
      if (done_exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        de = done_exp_q.pop_front();
        check("done_cycle", 128'(cyc), 128'(de.cyc));
        check("done_nr", 128'(nr), 128'(de.nr));
        check("done_ready", 128'(ready), 128'(1));
      end
      done_seen++;
    end
    if (err) begin
      if (err_exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_err: got err at cycle %0d expected none", cyc);
      end else begin
        ee = err_exp_q.pop_front();
        check("err_cycle", 128'(cyc), 128'(ee.cyc));
        check("err_ready", 128'(ready), 128'(ee.rdy));
      end
    end
    if (rd_pend) begin
      if (rd_exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_read: got %h expected no read", rk_out);
      end else begin
        re = rd_exp_q.pop_front();
        check(re.name, rk_out, re.val);
      end
    end
  end

  task automatic run(input logic [1:0] m, input logic [0:255] k, input logic [3:0] exp_nr,
                     input int lat, input bit pulse_mid);
    int  c;
    int  prev;
    bit  got;
    @(negedge clk);
    mode = m; key_in = k; start = 1'b1; c = cyc;
    prev = done_seen;
    done_exp_q.push_back('{c + lat + 1, exp_nr});
    @(negedge clk);
    start = 1'b0;
    #1;
    check("ready_drop", 128'(ready), 128'(0));
    check("busy_run", 128'(busy), 128'(1));
    if (pulse_mid) begin
      repeat (9) @(negedge clk);
      mode = 2'd3; start = 1'b1; key_in = ~k; rk_idx = 4'd15;
      @(negedge clk);
      start = 1'b0; mode = 2'd2;
    end
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      #1;
      if (done_seen != prev) got = 1'b1;
    end
    check("done_seen", 128'(got), 128'(1));
  endtask

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string name);
    @(negedge clk);
    rk_idx = idx; rd_strobe = 1'b1;
    rd_exp_q.push_back('{name, exp});
    @(negedge clk);
    rd_strobe = 1'b0;
  endtask

  task automatic err_probe(input logic rdy);
    @(negedge clk);
    mode = 2'd3; start = 1'b1;
    err_exp_q.push_back('{cyc + 1, rdy});
    @(negedge clk);
    start = 1'b0;
    #1;
    check("err_busy", 128'(busy), 128'(0));
    @(negedge clk);
    #1;
    check("err_pulse_len", 128'(err), 128'(0));
    check("err_ready_hold", 128'(ready), 128'(rdy));
    check("err_busy_hold", 128'(busy), 128'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_ready"}, 128'(ready), 128'(0));
    check({tag, "_err"}, 128'(err), 128'(0));
    check({tag, "_nr"}, 128'(nr), 128'(0));
    check({tag, "_rk"}, rk_out, 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // AES-128 with an ignored start (illegal mode, changed key) mid-run
    run(2'd0, K128, 4'd10, 41, 1'b1);
    rd(4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "aes128_rk0");
    rd(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "aes128_rk1");
    rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_rk10");
    rd(4'd15, 128'h0, "aes128_rk15_zero");

    err_probe(1'b1);

    run(2'd1, K192, 4'd12, 47, 1'b0);
    rd(4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5, "aes192_rk0");
    rd(4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5, "aes192_rk1");
    rd(4'd12, 128'he98ba06f448c773c8ecc720401002202, "aes192_rk12");
    rd(4'd13, 128'h0, "aes192_rk13_zero");

    run(2'd2, K256, 4'd14, 53, 1'b0);
    rd(4'd1,  128'h1f352c073b6108d72d9810a30914dff4, "aes256_rk1");
    rd(4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde, "aes256_rk2");
    rd(4'd3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a, "aes256_rk3");
    rd(4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "aes256_rk14");

    // Back-to-back restart from ready
    run(2'd0, K128, 4'd10, 41, 1'b0);
    #1 check("b2b_nr", 128'(nr), 128'(10));
    rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "b2b_rk10");
    for (int r = 11; r < 15; r++) rd(4'(r), 128'h0, $sformatf("b2b_rk%0d_zero", r));

    // Async reset at edge 20 of an AES-256 run
    @(negedge clk);
    rk_idx = 4'd0; mode = 2'd2; key_in = K256; start = 1'b1; c = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 40 && cyc != c + 20; n++) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("midrun_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    err_probe(1'b0);

    run(2'd0, K128, 4'd10, 41, 1'b0);
    rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "post_rst_rk10");
    rd(4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "post_rst_rk0");
    rd(4'd14, 128'h0, "post_rst_rk14_zero");

    repeat (4) @(negedge clk);
    check("sb_rd_drained", 128'(rd_exp_q.size()), 128'(0));
    check("sb_done_drained", 128'(done_exp_q.size()), 128'(0));
    check("sb_err_drained", 128'(err_exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/key_exp_iter.md
Name: key_exp_iter

Overview:
- Iterative, parametrised successor to the fully unrolled AES-128 key expander.
- Supports AES-128, AES-192 and AES-256, selected per run by `mode`.
- Generates one 32-bit schedule word per clock through a single shared SubWord unit (4 S-box lookups) and stores the words in an internal register file.
- Round keys are random-access by round index, feeding the round datapath of the AES core once `ready` is high.

Parameters:
- MAX_NK, 8, largest supported key length in words (4, 6 or 8). Storage depth = 4*(MAX_NK+7) words. Modes needing Nk > MAX_NK are rejected.
- RK_REG_OUT, 1, round-key read latency: 1 = registered `rk_out`, 0 = combinational.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request expansion; sampled only when not busy
- mode  in  2  0 = AES-128 (Nk4, Nr10), 1 = AES-192 (Nk6, Nr12), 2 = AES-256 (Nk8, Nr14), 3 = reserved
- key_in  in  [0:255]  cipher key, left-aligned, bit 0 = MSB; AES-128 uses [0:127], AES-192 uses [0:191]
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when the schedule is complete
- ready  out  1  schedule valid; level, held until next start or reset
- err  out  1  one-cycle pulse on start with an illegal mode
- nr  out  4  latched round count (10/12/14)
- rk_idx  in  4  round-key index 0..nr
- rk_out  out  [0:127]  {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r = rk_idx

Behaviour:
- Reset (async, any time, including mid-expansion):
  - state = IDLE; busy, done, ready, err = 0; nr = 0; rk_out = 0.
  - Word store cleared; rcon = 0x01; word counter i = 0.
- FSM states: IDLE, LOAD, EXP, FIN.
- IDLE:
  - start=1 with legal mode (mode≠3 and Nk≤MAX_NK): latch mode, Nk and nr; capture key_in; ready→0; go to LOAD.
  - start=1 with illegal mode: err pulses for 1 cycle; stay IDLE; ready unchanged.
- LOAD (1 cycle): write w[0..Nk-1] from the key; set i = Nk, rcon = 0x01, k = 0 (k tracks i mod Nk); go to EXP.
- EXP: one word written per edge.
  - temp = w[i-1].
  - If k==0: temp = SubWord(RotWord(temp)) ^ {rcon, 00, 00, 00}; then rcon = xtime(rcon) (0x80→0x1B, 0x1B→0x36).
  - Else if Nk==8 and k==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp; then i++, k = (k==Nk-1) ? 0 : k+1. No divider.
  - After writing w[4*(nr+1)-1] (w43 / w51 / w59), go to FIN.
- FIN (1 cycle): done=1, ready=1, busy=0; next state IDLE.
- busy is 1 in LOAD and EXP only.
- Latency (start sampled at edge 0): LOAD write at edge 1; last word at edge 1+(4(nr+1)-Nk), i.e. edge 41 / 47 / 53; done high in the following cycle.
- start while busy: ignored; no err.
- start while ready: accepted; a restart drops ready the cycle after start is sampled.
- Read port:
  - RK_REG_OUT=1: rk_out updates one edge after rk_idx.
  - RK_REG_OUT=0: rk_out is combinational.
  - rk_idx > nr returns all-zero.
  - Reads while ready=0 return stale or zero data; consumers must gate on ready.
- key_in, mode and rk_idx changes during busy do not affect the run in progress.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start at edge 0 → done in cycle after edge 41; rk_idx=10 → rk_out = d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx=0 → the key itself.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done after edge 47; nr=12; rk_idx=12 → e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done after edge 53; nr=14; rk_idx=14 → fe4890d1e6188d0b046df344706c631e (exercises the k==4 SubWord path).
- mode=3 with start → err pulses 1 cycle; busy stays 0; ready keeps its prior value. Also: start pulsed mid-run → ignored, same done timing; rk_idx=15 → zero.
- rst asserted at edge 20 of an AES-256 run → all outputs 0 immediately (asynchronously). Then restart with the AES-128 vector → correct round-10 key, no residue from the earlier run.
- Back-to-back: AES-256 run completes, then AES-128 start → ready falls the next cycle; nr=10 after done; rk_idx 11..14 read zero.
